// File: rtl/udp_echo_buf_pkg.sv
// Shared definitions for the UDP echo buffer: FSM states, RX/TX word indices
// and the UDP header length.
package udp_echo_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SUBMIT,
    ST_WAIT_TX,
    ST_RELEASE
  } state_t;

  localparam int RX_W_SRCIP   = 0;
  localparam int RX_W_LENPORT = 1;
  localparam int RX_W_PAYLOAD = 2;

  localparam int TX_W_DSTIP   = 0;
  localparam int TX_W_PORTS   = 1;
  localparam int TX_W_LEN     = 2;
  localparam int TX_W_PAYLOAD = 3;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  // Largest payload that fits the TX window behind the three header words.
  function automatic logic [15:0] max_payload_bytes(input int aw);
    return 16'(((1 << aw) - 3) * 4);
  endfunction

endpackage

// File: rtl/udp_echo_ram.sv
// Simple dual-port datagram RAM: one write port, one synchronous read port.
module udp_echo_ram #(
  parameter int AWIDTH = 6
) (
  input  logic              clk_int,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**AWIDTH)-1];

  always_ff @(posedge clk_int) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_int) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_echo_buf.sv
// Captures a received UDP datagram, serves an echo reply to the TX side,
// then hands the RX buffer back to the core.
module udp_echo_buf import udp_echo_buf_pkg::*; #(
  parameter int          AWIDTH        = 6,
  parameter logic [15:0] ECHO_SRC_PORT = 16'd1234,
  parameter int          TX_TIMEOUT    = 125000000
) (
  input  logic              clk_int,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [AWIDTH-1:0] rxbuf_addr,
  input  logic              rxbuf_ce,
  input  logic              rxbuf_we,
  input  logic [31:0]       rxbuf_wdata,
  input  logic              rxbuf_grant,
  output logic              rxbuf_rel,
  input  logic [AWIDTH-1:0] txbuf_addr,
  input  logic              txbuf_ce,
  output logic [31:0]       txbuf_rdata,
  input  logic              txbuf_grant,
  output logic              txbuf_rel,
  output logic              busy,
  output logic [15:0]       echo_count,
  output logic [15:0]       drop_count
);

  localparam logic [15:0] MAX_LEN  = max_payload_bytes(AWIDTH);
  localparam logic [31:0] TMO_LAST = 32'(TX_TIMEOUT - 1);

  state_t      state;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic [15:0] udp_length;
  logic [15:0] payload_len;
  logic [15:0] len_raw;
  logic [31:0] tmo_cnt;
  logic        rx_wr;
  logic        hdr_sel;
  logic [31:0] hdr_q;
  logic [31:0] ram_q;

  // The RX buffer is only ours while idle; later writes must not disturb a reply.
  assign rx_wr   = rxbuf_ce & rxbuf_we & (state == ST_IDLE);
  assign len_raw = udp_length - UDP_HDR_LEN;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      src_ip     <= '0;
      src_port   <= '0;
      udp_length <= '0;
    end else if (rx_wr) begin
      if (rxbuf_addr == AWIDTH'(RX_W_SRCIP)) src_ip <= rxbuf_wdata;
      if (rxbuf_addr == AWIDTH'(RX_W_LENPORT)) begin
        udp_length <= rxbuf_wdata[31:16];
        src_port   <= rxbuf_wdata[15:0];
      end
    end
  end

  // TX word 3+k maps onto RX word 2+k.
  udp_echo_ram #(.AWIDTH(AWIDTH)) u_ram (
    .clk_int (clk_int),
    .we      (rx_wr),
    .waddr   (rxbuf_addr),
    .wdata   (rxbuf_wdata),
    .re      (txbuf_ce),
    .raddr   (txbuf_addr - AWIDTH'(TX_W_PAYLOAD - RX_W_PAYLOAD)),
    .rdata   (ram_q)
  );

  // Header words and the RAM word are both captured on txbuf_ce, so the
  // muxed output is a registered value that holds between reads.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      hdr_sel <= 1'b1;
      hdr_q   <= '0;
    end else if (txbuf_ce) begin
      hdr_sel <= (txbuf_addr < AWIDTH'(TX_W_PAYLOAD));
      case (txbuf_addr)
        AWIDTH'(TX_W_DSTIP): hdr_q <= src_ip;
        AWIDTH'(TX_W_PORTS): hdr_q <= {ECHO_SRC_PORT, src_port};
        AWIDTH'(TX_W_LEN):   hdr_q <= {16'h0, payload_len};
        default:             hdr_q <= '0;
      endcase
    end
  end

  assign txbuf_rdata = hdr_sel ? hdr_q : ram_q;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      txbuf_rel   <= 1'b0;
      rxbuf_rel   <= 1'b0;
      echo_count  <= '0;
      drop_count  <= '0;
      payload_len <= '0;
      tmo_cnt     <= '0;
    end else begin
      txbuf_rel <= 1'b0;
      rxbuf_rel <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rxbuf_grant) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if ((udp_length < UDP_HDR_LEN) || (len_raw == 16'd0) || !enable) begin
            drop_count <= drop_count + 16'd1;
            state      <= ST_RELEASE;
          end else begin
            payload_len <= (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
            state       <= ST_SUBMIT;
          end
        end
        ST_SUBMIT: begin
          txbuf_rel <= 1'b1;
          tmo_cnt   <= '0;
          state     <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (txbuf_grant) begin
            echo_count <= echo_count + 16'd1;
            state      <= ST_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            drop_count <= drop_count + 16'd1;
            state      <= ST_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_RELEASE: begin
          rxbuf_rel <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
